dsm_dac_ctrl: RTL and testbench
===============================

// Module: dsm_dac_ctrl
// PURPOSE
//   Sample scheduler and soft-mute sequencer in front of dsm_dac. Accepts signed
//   8-bit samples from an upstream source over valid/ready. Generates the DAC
//   enb oversampling strobe and presents one sample to dsm_in per OSR strobes.
//   Handles underflow with silence (0x00) and ramps the output to zero before stopping.
// PARAMETERS
//   CLK_DIV    4    clk cycles per enb strobe (>=2)
//   OSR        64   enb strobes per sample period (>=2)
//   MUTE_STEP  8    magnitude decrement of dsm_in per sample period in MUTE (1..127)
// PORTS
//   clk            in   1   system clock, all logic on posedge
//   rst_n          in   1   synchronous active-low reset
//   en             in   1   1 = stream, 0 = mute then stop (level)
//   s_valid        in   1   upstream sample valid
//   s_data         in   8   upstream sample, signed two's complement
//   s_ready        out  1   sample accepted when s_valid & s_ready on a posedge
//   dsm_in         out  8   signed sample to dsm_dac.dsm_in (registered)
//   enb            out  1   one-clk strobe to dsm_dac.enb (registered)
//   running        out  1   1 in RUN or MUTE
//   underflow_cnt  out  16  count of empty sample boundaries in RUN, saturates at 0xFFFF
// BEHAVIOUR
//   Reset (rst_n=0 at posedge): state=IDLE, dsm_in=0, enb=0, s_ready=0, running=0,
//     underflow_cnt=0, buffer empty, div_cnt=osr_cnt=0. Reset has priority in every state.
//   s_ready = (state==PRIME | state==RUN) & ~buf_full, registered-state-derived, no s_valid path.
//   One-entry buffer: a handshake in RUN writes buf and sets buf_full.
//   Prescaler: div_cnt counts 0..CLK_DIV-1 in RUN/MUTE and wraps. enb=1 for the cycle after
//     div_cnt==CLK_DIV-1, so enb is 1 every CLK_DIV clks. osr_cnt increments on each enb
//     and wraps at OSR-1. Sample boundary = enb cycle with osr_cnt==OSR-1.
//   Boundary update: dsm_in changes on the boundary edge; the first enb carrying it is the next one.
//   FSM:
//     IDLE : counters held at 0, enb=0, dsm_in=0. en=1 -> PRIME.
//     PRIME: s_ready=1. Handshake -> dsm_in<=s_data, state RUN, div_cnt=osr_cnt=0 (first enb
//            CLK_DIV clks later). en=0 -> IDLE.
//     RUN  : at boundary, if buf_full then dsm_in<=buf and buf_full<=0. Otherwise dsm_in<=0x00
//            and underflow_cnt++ (saturating).
//            A handshake in the boundary cycle with buf empty still counts as underflow.
//            That sample is stored in buf and used at the next boundary.
//            en=0 -> MUTE next cycle; buf discarded, s_ready=0, counters keep running.
//     MUTE : at each boundary, dsm_in steps toward 0 by MUTE_STEP (signed compare).
//            If |dsm_in|<=MUTE_STEP then dsm_in<=0; never overshoots sign.
//            -128 is handled without overflow (first step gives -128+MUTE_STEP).
//            At a boundary where dsm_in is already 0 -> IDLE (enb stops that cycle).
//            en is ignored in MUTE; if en=1 on reaching IDLE, PRIME follows next cycle.
//   underflow_cnt cleared by reset only; not incremented in PRIME/MUTE.
// TESTING  (CLK_DIV=4, OSR=8, MUTE_STEP=16: enb every 4 clks, boundary every 32 clks)
//   Reset with en=1, s_valid=1 held -> dsm_in=0, enb=0, s_ready=0, running=0, IDLE; after
//     release PRIME within 1 clk.
//   en=1, push 0x40 then 0x10 -> dsm_in=0x40 the clk after the first handshake; enb each 4 clks.
//     s_ready=0 while 0x10 is buffered; dsm_in=0x10 after the 8th enb; s_ready back to 1.
//   RUN with no s_valid through a boundary -> dsm_in=0x00, underflow_cnt=1. Repeat 3 boundaries
//     -> 4. Force cnt 0xFFFF -> holds at 0xFFFF.
//   Handshake 0x22 in the exact boundary cycle with buf empty -> dsm_in=0x00, underflow_cnt+1.
//     Next boundary -> dsm_in=0x22.
//   dsm_in=0x85 (-123), drop en -> boundaries give -107,-91,-75,-59,-43,-27,-11,0, then IDLE.
//     enb stops, running=0. Repeat with 0x80 -> -112,...,-16,0.
//   rst_n=0 for 1 clk mid-RUN with buf full -> next clk all outputs at reset values.
//     Buffered sample lost; re-start requires a new PRIME handshake.

Source files
------------

// File: rtl/dsm_dac_ctrl_if.sv
// Sample stream from the upstream source into dsm_dac_ctrl.
// valid/data flow source -> controller, ready flows back; a transfer
// happens on any posedge where valid and ready are both high.
interface dsm_dac_ctrl_if;
  logic              valid;
  logic signed [7:0] data;
  logic              ready;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );
endinterface

// File: rtl/dsm_dac_ctrl.sv
// Sample scheduler and soft-mute sequencer placed in front of dsm_dac.
// Derives the enb oversampling strobe from clk, hands dsm_dac one new
// sample every OSR strobes, fills empty periods with silence, and on
// mute ramps the held sample to zero before stopping the strobe.
module dsm_dac_ctrl #(
  parameter int CLK_DIV   = 4,   // clk cycles per enb strobe (>=2)
  parameter int OSR       = 64,  // enb strobes per sample period (>=2)
  parameter int MUTE_STEP = 8    // magnitude decrement per period in MUTE (1..127)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  dsm_dac_ctrl_if.slave     s,
  output logic signed [7:0] dsm_in,
  output logic              enb,
  output logic              running,
  output logic [15:0]       underflow_cnt
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int OSR_W = (OSR > 1) ? $clog2(OSR) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_ONE  = DIV_W'(1);
  localparam logic [OSR_W-1:0]  OSR_LAST = OSR_W'(OSR - 1);
  localparam logic [OSR_W-1:0]  OSR_ONE  = OSR_W'(1);
  localparam logic signed [8:0] STEP9    = 9'(MUTE_STEP);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    MUTE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [OSR_W-1:0]  osr_cnt_q, osr_cnt_d;
  logic              enb_q, enb_d;
  logic signed [7:0] dsm_q, dsm_d;
  logic signed [7:0] buf_q, buf_d;
  logic              buf_full_q, buf_full_d;
  logic [15:0]       underflow_cnt_q, underflow_cnt_d;

  logic              s_ready;
  logic              hs;
  logic              boundary;
  logic              active;

  // Underflow counter sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    logic [15:0] r;
    if (v == 16'hFFFF) r = v;
    else               r = v + 16'd1;
    return r;
  endfunction

  // One mute step toward zero. Work in 9 bits so -128 plus the step and
  // the negated step never overflow; small magnitudes land exactly on 0.
  function automatic logic signed [7:0] mute_step(input logic signed [7:0] v);
    logic signed [8:0] w;
    logic signed [8:0] r;
    w = {v[7], v};
    if (w > 9'sd0) begin
      if (w <= STEP9) r = 9'sd0;
      else            r = w - STEP9;
    end else if (w < 9'sd0) begin
      if (w >= -STEP9) r = 9'sd0;
      else             r = w + STEP9;
    end else begin
      r = 9'sd0;
    end
    return r[7:0];
  endfunction

  // Ready depends only on registered state, never on valid.
  assign active   = (state_q == RUN) || (state_q == MUTE);
  assign s_ready  = ((state_q == PRIME) || (state_q == RUN)) && !buf_full_q;
  assign hs       = s.valid && s_ready;
  assign boundary = enb_q && (osr_cnt_q == OSR_LAST);

  assign s.ready       = s_ready;
  assign dsm_in        = dsm_q;
  assign enb           = enb_q;
  assign running       = active;
  assign underflow_cnt = underflow_cnt_q;

  // Next-state logic: prescaler, sample scheduling and the mute ramp.
  always_comb begin
    state_d         = state_q;
    div_cnt_d       = div_cnt_q;
    osr_cnt_d       = osr_cnt_q;
    enb_d           = 1'b0;
    dsm_d           = dsm_q;
    buf_d           = buf_q;
    buf_full_d      = buf_full_q;
    underflow_cnt_d = underflow_cnt_q;

    // The strobe follows the cycle in which the divider sits at its last
    // count; osr_cnt advances once per strobe.
    if (active) begin
      if (div_cnt_q == DIV_LAST) div_cnt_d = '0;
      else                       div_cnt_d = div_cnt_q + DIV_ONE;
      enb_d = (div_cnt_q == DIV_LAST);
      if (enb_q) begin
        if (osr_cnt_q == OSR_LAST) osr_cnt_d = '0;
        else                       osr_cnt_d = osr_cnt_q + OSR_ONE;
      end
    end

    case (state_q)
      IDLE: begin
        div_cnt_d  = '0;
        osr_cnt_d  = '0;
        dsm_d      = '0;
        buf_full_d = 1'b0;
        if (en) state_d = PRIME;
      end

      PRIME: begin
        div_cnt_d  = '0;
        osr_cnt_d  = '0;
        buf_full_d = 1'b0;
        // The priming sample goes straight to the output; the first strobe
        // carrying it comes CLK_DIV clocks later.
        if (hs) begin
          dsm_d   = s.data;
          state_d = RUN;
        end else if (!en) begin
          state_d = IDLE;
        end
      end

      RUN: begin
        if (hs) begin
          buf_d      = s.data;
          buf_full_d = 1'b1;
        end
        // A sample arriving in the boundary cycle itself is too late for
        // this period: the period is silent and the sample waits a period.
        if (boundary) begin
          if (buf_full_q) begin
            dsm_d      = buf_q;
            buf_full_d = 1'b0;
          end else begin
            dsm_d           = '0;
            underflow_cnt_d = sat_inc(underflow_cnt_q);
          end
        end
        if (!en) begin
          state_d    = MUTE;
          buf_full_d = 1'b0;
        end
      end

      MUTE: begin
        if (boundary) begin
          if (dsm_q == 8'sd0) begin
            state_d   = IDLE;
            enb_d     = 1'b0;
            div_cnt_d = '0;
            osr_cnt_d = '0;
          end else begin
            dsm_d = mute_step(dsm_q);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Control and output registers; reset wins in every state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      div_cnt_q       <= '0;
      osr_cnt_q       <= '0;
      enb_q           <= 1'b0;
      dsm_q           <= '0;
      buf_full_q      <= 1'b0;
      underflow_cnt_q <= '0;
    end else begin
      state_q         <= state_d;
      div_cnt_q       <= div_cnt_d;
      osr_cnt_q       <= osr_cnt_d;
      enb_q           <= enb_d;
      dsm_q           <= dsm_d;
      buf_full_q      <= buf_full_d;
      underflow_cnt_q <= underflow_cnt_d;
    end
  end

  // Buffer payload; its validity lives in buf_full_q, so no reset here.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

endmodule

// File: tb/tb_dsm_dac_ctrl.sv
// Self-checking bench for dsm_dac_ctrl with CLK_DIV=4, OSR=8, MUTE_STEP=16.
module tb_dsm_dac_ctrl;

  localparam int CLK_DIV   = 4;
  localparam int OSR       = 8;
  localparam int MUTE_STEP = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic signed [7:0] dsm_in;
  logic              enb;
  logic              running;
  logic [15:0]       underflow_cnt;

  dsm_dac_ctrl_if s_if ();

  dsm_dac_ctrl #(
    .CLK_DIV  (CLK_DIV),
    .OSR      (OSR),
    .MUTE_STEP(MUTE_STEP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .s            (s_if),
    .dsm_in       (dsm_in),
    .enb          (enb),
    .running      (running),
    .underflow_cnt(underflow_cnt)
  );

  always #5 clk = ~clk;

  int          n_tot   = 0;
  int          n_bad   = 0;
  int          enb_cnt = 0;
  int          bnd     = 0;
  int          snap;
  logic [15:0] uf_exp;
  logic [7:0]  exp_q[$];

  // Count strobes mid-cycle, away from the edges that change enb.
  always @(negedge clk) begin
    if (enb) enb_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    bit done;
    done = 1'b0;
    s_if.valid = 1'b1;
    s_if.data  = d;
    for (int i = 0; i < 100 && !done; i++) begin
      if (s_if.ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    s_if.valid = 1'b0;
    chk("hs_done", {31'd0, done}, 32'd1);
  endtask

  task automatic wait_bnd();
    bnd += OSR;
    for (int i = 0; i < 400 && enb_cnt < bnd; i++) @(posedge clk);
    #1;
    chk("bnd_reached", enb_cnt, bnd);
  endtask

  task automatic pop_chk(input string tag);
    logic [7:0] e;
    e = 8'hxx;
    if (exp_q.size() != 0) e = exp_q.pop_front();
    chk(tag, {24'd0, dsm_in}, {24'd0, e});
  endtask

  function automatic int mute_model(input int v);
    if (v > MUTE_STEP)  return v - MUTE_STEP;
    if (v < -MUTE_STEP) return v + MUTE_STEP;
    return 0;
  endfunction

  task automatic push_mute(input int start);
    int v;
    v = start;
    do begin
      v = mute_model(v);
      exp_q.push_back(8'(v));
    end while (v != 0);
    exp_q.push_back(8'h00);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst_n      = 1'b0;
    en         = 1'b1;
    s_if.valid = 1'b1;
    s_if.data  = 8'h55;
    tick(3);
    chk("rst_dsm", {24'd0, dsm_in}, 32'h0);
    chk("rst_enb", {31'd0, enb}, 32'd0);
    chk("rst_rdy", {31'd0, s_if.ready}, 32'd0);
    chk("rst_run", {31'd0, running}, 32'd0);
    chk("rst_uf", {16'd0, underflow_cnt}, 32'h0);

    rst_n      = 1'b1;
    s_if.valid = 1'b0;
    tick(1);
    chk("prime_rdy", {31'd0, s_if.ready}, 32'd1);
    chk("prime_run", {31'd0, running}, 32'd0);

    // Priming sample, strobe spacing, then one buffered sample.
    exp_q.push_back(8'h40);
    send(8'h40);
    pop_chk("first_dsm");
    chk("run_run", {31'd0, running}, 32'd1);
    bnd = enb_cnt;
    chk("enb_e0", {31'd0, enb}, 32'd0);
    tick(3);
    chk("enb_e3", {31'd0, enb}, 32'd0);
    tick(1);
    chk("enb_e4", {31'd0, enb}, 32'd1);
    tick(1);
    chk("enb_e5", {31'd0, enb}, 32'd0);
    tick(3);
    chk("enb_e8", {31'd0, enb}, 32'd1);
    exp_q.push_back(8'h10);
    send(8'h10);
    chk("buf_rdy", {31'd0, s_if.ready}, 32'd0);
    wait_bnd();
    pop_chk("bnd1_dsm");
    chk("rdy_back", {31'd0, s_if.ready}, 32'd1);
    chk("uf_zero", {16'd0, underflow_cnt}, 32'h0);

    // Empty periods.
    uf_exp = 16'd0;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(8'h00);
      wait_bnd();
      pop_chk("uf_dsm");
      uf_exp = uf_exp + 16'd1;
      chk("uf_cnt", {16'd0, underflow_cnt}, {16'd0, uf_exp});
    end

    // Handshake landing exactly on the boundary edge.
    for (int i = 0; i < 400 && !(enb && enb_cnt == bnd + OSR - 1); i++) begin
      @(posedge clk);
      #1;
    end
    exp_q.push_back(8'h00);
    s_if.valid = 1'b1;
    s_if.data  = 8'h22;
    @(posedge clk);
    #1;
    s_if.valid = 1'b0;
    bnd += OSR;
    chk("bhs_edge", enb_cnt, bnd);
    pop_chk("bhs_dsm");
    uf_exp = uf_exp + 16'd1;
    chk("bhs_uf", {16'd0, underflow_cnt}, {16'd0, uf_exp});
    chk("bhs_rdy", {31'd0, s_if.ready}, 32'd0);
    exp_q.push_back(8'h22);
    wait_bnd();
    pop_chk("bhs_next");
    chk("bhs_uf2", {16'd0, underflow_cnt}, {16'd0, uf_exp});

    // Mute ramp from -123.
    exp_q.push_back(8'h85);
    send(8'h85);
    wait_bnd();
    pop_chk("m1_load");
    en = 1'b0;
    push_mute(-123);
    tick(1);
    chk("m1_run", {31'd0, running}, 32'd1);
    chk("m1_rdy", {31'd0, s_if.ready}, 32'd0);
    while (exp_q.size() != 0) begin
      wait_bnd();
      pop_chk("m1_step");
    end
    chk("m1_idle_run", {31'd0, running}, 32'd0);
    chk("m1_idle_enb", {31'd0, enb}, 32'd0);
    chk("m1_uf", {16'd0, underflow_cnt}, {16'd0, uf_exp});
    snap = enb_cnt;
    tick(20);
    chk("m1_enb_stop", enb_cnt, snap);
    chk("m1_idle_dsm", {24'd0, dsm_in}, 32'h0);

    // Mute ramp from -128, primed straight into the output.
    en = 1'b1;
    tick(1);
    chk("m2_prime_rdy", {31'd0, s_if.ready}, 32'd1);
    exp_q.push_back(8'h80);
    send(8'h80);
    pop_chk("m2_load");
    bnd = enb_cnt;
    en  = 1'b0;
    push_mute(-128);
    while (exp_q.size() != 0) begin
      wait_bnd();
      pop_chk("m2_step");
    end
    chk("m2_idle_run", {31'd0, running}, 32'd0);

    // Saturation of the underflow counter.
    en = 1'b1;
    tick(1);
    exp_q.push_back(8'h11);
    send(8'h11);
    pop_chk("sat_load");
    bnd = enb_cnt;
    force dut.underflow_cnt_q = 16'hFFFF;
    tick(1);
    release dut.underflow_cnt_q;
    tick(1);
    chk("sat_pre", {16'd0, underflow_cnt}, 32'hFFFF);
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(8'h00);
      wait_bnd();
      pop_chk("sat_dsm");
      chk("sat_uf", {16'd0, underflow_cnt}, 32'hFFFF);
    end

    // Reset mid-RUN with the buffer full.
    send(8'h33);
    chk("mr_rdy", {31'd0, s_if.ready}, 32'd0);
    rst_n = 1'b0;
    tick(1);
    chk("mr_dsm", {24'd0, dsm_in}, 32'h0);
    chk("mr_enb", {31'd0, enb}, 32'd0);
    chk("mr_rdy0", {31'd0, s_if.ready}, 32'd0);
    chk("mr_run", {31'd0, running}, 32'd0);
    chk("mr_uf", {16'd0, underflow_cnt}, 32'h0);
    rst_n = 1'b1;
    tick(1);
    chk("mr_prime_rdy", {31'd0, s_if.ready}, 32'd1);
    snap = enb_cnt;
    tick(40);
    chk("mr_no_enb", enb_cnt, snap);
    chk("mr_hold_dsm", {24'd0, dsm_in}, 32'h0);
    chk("mr_hold_run", {31'd0, running}, 32'd0);
    exp_q.push_back(8'h5A);
    send(8'h5A);
    pop_chk("mr_restart");
    chk("mr_restart_run", {31'd0, running}, 32'd1);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
